// File: rtl/inst_hw_emit_pkg.sv
// Shared definitions for the halfword emit/fetch pair: length rule, FSM encodings, FIFO entry.
// The optional instruction counters are enabled by defining INST_HW_EMIT_CNT_EN.
package inst_hw_emit_pkg;

    localparam int HW_W = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HI   = 2'd1;
    localparam logic [1:0] S_LO   = 2'd2;

    typedef struct packed {
        logic        is32;
        logic [31:0] inst;
    } fifo_entry_t;

    // Same rule the fetch side uses to reassemble halfwords into instructions.
    function automatic logic is_inst32(input logic [HW_W-1:0] hw);
        return (hw[15:13] == 3'b111) && (hw[12:11] != 2'b00);
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO for whole instructions awaiting serialisation; push while full is ignored.
module inst_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push & !full;
    assign do_pop  = pop & !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage carries no reset; only the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_hw_emit.sv
// Halfword emitter: buffers 16/32-bit instructions and streams them out as 16-bit halfwords.
// Define INST_HW_EMIT_CNT_EN to add the cnt16/cnt32 completed-instruction counters.
module inst_hw_emit
    import inst_hw_emit_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     in_inst,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [HW_W-1:0] out_hw,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_first,
    output logic            busy
`ifdef INST_HW_EMIT_CNT_EN
    ,
    output logic [15:0]     cnt16,
    output logic [15:0]     cnt32
`endif
);

    fifo_entry_t     wr_entry;
    fifo_entry_t     rd_entry;
    logic            full;
    logic            empty;
    logic            pop;
    logic            xfer;
    logic            ready_q;
    logic [1:0]      state;
    logic [HW_W-1:0] lo_hw;
    logic            is32_q;

    assign wr_entry.is32 = is_inst32(in_inst[31:16]);
    assign wr_entry.inst = in_inst;
    // ready_q holds in_ready low through reset and for the edge that releases it.
    assign in_ready      = ready_q & !full;
    assign busy          = !empty | out_valid;

    inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid & in_ready),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty)
    );

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        xfer = out_valid & out_ready;
        pop  = 1'b0;
        case (state)
            S_IDLE:  pop = !empty;
            S_HI:    pop = xfer & !is32_q & !empty;
            S_LO:    pop = xfer & !empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q   <= 1'b0;
            state     <= S_IDLE;
            out_hw    <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            lo_hw     <= '0;
            is32_q    <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (pop) begin
                state     <= S_HI;
                out_hw    <= rd_entry.inst[31:16];
                lo_hw     <= rd_entry.inst[15:0];
                is32_q    <= rd_entry.is32;
                out_valid <= 1'b1;
                out_first <= 1'b1;
            end else if (xfer) begin
                if (state == S_HI && is32_q) begin
                    state     <= S_LO;
                    out_hw    <= lo_hw;
                    out_first <= 1'b0;
                end else begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    out_first <= 1'b0;
                end
            end
        end
    end

`ifdef INST_HW_EMIT_CNT_EN
    // An instruction completes when its last halfword transfers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt16 <= '0;
            cnt32 <= '0;
        end else if (xfer) begin
            if (state == S_HI && !is32_q && cnt16 != 16'hFFFF) cnt16 <= cnt16 + 16'd1;
            if (state == S_LO && cnt32 != 16'hFFFF)            cnt32 <= cnt32 + 16'd1;
        end
    end
`endif

endmodule
